// File: rtl/uart_tx_buffer.sv
// Transmit holding FIFO feeding the UART TX control unit: queues bytes from the
// register side, launches them one per frame and holds byte + parity for the frame.
module uart_tx_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  tx_enable,
  input  logic                  parity_odd,
  input  logic                  busy,
  input  logic                  clr_overflow,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  parity_bit,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  tx_idle,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARMED     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    data_valid_q;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  logic                    parity_bit_q;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    overflow_q, overflow_d;

  logic                    push;
  logic                    pop;
  logic [DATA_WIDTH-1:0]   head;

  // full/empty come from the registered count, so a write landing in the
  // same cycle as a pop from a full FIFO is still dropped.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  assign push = wr_en & ~full;
  assign pop  = (state_q == S_IDLE) & tx_enable & ~empty & ~busy;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (clr_overflow)  overflow_d = 1'b0;
    if (wr_en && full) overflow_d = 1'b1;
  end

  always_ff @(posedge UCLK) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge UCLK) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Handshake: data_valid is a one-cycle launch pulse; the downstream unit
  // raises busy for the frame, and the next launch waits until busy has fallen.
  always_ff @(posedge UCLK) begin
    if (reset) begin
      state_q      <= S_IDLE;
      data_valid_q <= 1'b0;
      tx_data_q    <= '0;
      parity_bit_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            tx_data_q    <= head;
            parity_bit_q <= (^head) ^ parity_odd;
            data_valid_q <= 1'b1;
            state_q      <= S_ARMED;
          end
        end
        S_ARMED: begin
          data_valid_q <= 1'b0;
          state_q      <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (busy) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!busy) state_q <= S_IDLE;
        end
        default: begin
          data_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign data_valid = data_valid_q;
  assign tx_data    = tx_data_q;
  assign parity_bit = parity_bit_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign tx_idle    = (state_q == S_IDLE) & empty;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: scoreboard of launched bytes, a busy
// model standing in for the TX control unit, and directed FIFO/FSM scenarios.
module tb_uart_tx_buffer;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [W-1:0]     wr_data;
  logic             tx_enable;
  logic             parity_odd;
  logic             busy;
  logic             clr_overflow;
  logic             data_valid;
  logic [W-1:0]     tx_data;
  logic             parity_bit;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             tx_idle;
  logic [1:0]       dbg_state;

  int           n_checks = 0;
  int           n_errors = 0;
  int           dv_cnt   = 0;
  int           base;
  logic         dv_prev  = 1'b0;
  logic [W-1:0] last_byte = '0;
  logic         last_par  = 1'b0;
  bit           have_last = 1'b0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_buffer #(.DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
    .UCLK        (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .tx_enable   (tx_enable),
    .parity_odd  (parity_odd),
    .busy        (busy),
    .clr_overflow(clr_overflow),
    .data_valid  (data_valid),
    .tx_data     (tx_data),
    .parity_bit  (parity_bit),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .tx_idle     (tx_idle),
    .dbg_state   (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Stand-in for the TX control unit: busy for 11 cycles per launched frame.
  initial begin
    busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (data_valid && !reset) begin
        busy = 1'b1;
        for (int i = 0; i < 11; i++) begin
          @(posedge clk);
          if (reset) break;
        end
        #1;
        busy = 1'b0;
      end
    end
  end

  // Scoreboard and hold monitor.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (data_valid) begin
          dv_cnt++;
          check("dv_single_cycle", 32'(dv_prev), 0);
          check("launch_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("tx_data", 32'(tx_data), 32'(e));
            check("parity_bit", 32'(parity_bit), 32'((^e) ^ parity_odd));
            last_byte = e;
            last_par  = (^e) ^ parity_odd;
            have_last = 1'b1;
          end
        end else if (busy && have_last) begin
          check("hold_tx_data", 32'(tx_data), 32'(last_byte));
          check("hold_parity", 32'(parity_bit), 32'(last_par));
        end
      end
      dv_prev = data_valid;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [W-1:0] b, input bit accept, input bit clr);
    wr_en        = 1'b1;
    wr_data      = b;
    clr_overflow = clr;
    tick();
    wr_en        = 1'b0;
    clr_overflow = 1'b0;
    if (accept) exp_q.push_back(b);
  endtask

  task automatic wait_idle(input int limit, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx_idle && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, 32'(done), 1);
    tick();
  endtask

  task automatic wait_state(input logic [1:0] st, input int limit, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (dbg_state == st) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, 32'(done), 1);
    tick();
  endtask

  // Cycles from the first sample of busy low to the sample showing data_valid.
  task automatic measure_gap();
    int n = 99;
    bit hi = 1'b0;
    bit lo = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) begin hi = 1'b1; break; end
    end
    if (hi) begin
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (!busy) begin lo = 1'b1; break; end
      end
    end
    if (lo) begin
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (data_valid) begin n = i; break; end
      end
    end
    check("b2b_gap", n, 2);
  endtask

  initial begin
    reset        = 1'b1;
    wr_en        = 1'b0;
    wr_data      = '0;
    tx_enable    = 1'b0;
    parity_odd   = 1'b0;
    clr_overflow = 1'b0;
    repeat (3) tick();

    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_data_valid", 32'(data_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_parity", 32'(parity_bit), 0);
    check("rst_tx_idle", 32'(tx_idle), 1);
    reset = 1'b0;
    tick();

    // Single byte: launch two cycles after the write.
    tx_enable = 1'b1;
    write_byte(8'hA5, 1'b1, 1'b0);
    check("t2_count_after_write", 32'(count), 1);
    check("t2_dv_early", 32'(data_valid), 0);
    tick();
    check("t2_dv", 32'(data_valid), 1);
    check("t2_tx_data", 32'(tx_data), 'hA5);
    check("t2_parity", 32'(parity_bit), 0);
    check("t2_count_after_pop", 32'(count), 0);
    check("t2_empty", 32'(empty), 1);
    tick();
    check("t2_dv_low", 32'(data_valid), 0);
    wait_idle(100, "t2_idle");
    check("t2_tx_data_held", 32'(tx_data), 'hA5);

    // Back-to-back frames with odd parity.
    parity_odd = 1'b1;
    write_byte(8'h01, 1'b1, 1'b0);
    write_byte(8'h02, 1'b1, 1'b0);
    write_byte(8'h03, 1'b1, 1'b0);
    measure_gap();
    measure_gap();
    wait_idle(100, "t3_idle");
    parity_odd = 1'b0;

    // Fill past full with transmitter disabled, then drain.
    tx_enable = 1'b0;
    base = dv_cnt;
    for (int i = 0; i < DEPTH; i++) write_byte(8'(i * 13 + 7), 1'b1, 1'b0);
    write_byte(8'hEE, 1'b0, 1'b0);
    check("t4_full", 32'(full), 1);
    check("t4_count", 32'(count), DEPTH);
    check("t4_overflow", 32'(overflow), 1);
    check("t4_empty", 32'(empty), 0);
    write_byte(8'h77, 1'b0, 1'b1);
    check("t4_ovf_set_wins", 32'(overflow), 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("t4_ovf_cleared", 32'(overflow), 0);
    check("t4_no_launch", dv_cnt - base, 0);
    tx_enable = 1'b1;
    wait_idle(600, "t4_drain");
    check("t4_launch_count", dv_cnt - base, DEPTH);

    // Wrap-around with writes interleaved with drains.
    base = dv_cnt;
    for (int i = 0; i < 40; i++) begin
      write_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
      repeat ($urandom_range(9, 19)) tick();
    end
    wait_idle(800, "t5_drain");
    check("t5_launch_count", dv_cnt - base, 40);

    // Write and pop in the same cycle, then overflowing write during a pop.
    tx_enable = 1'b0;
    for (int i = 0; i < 5; i++) write_byte(8'(8'h50 + i), 1'b1, 1'b0);
    check("t6_count5", 32'(count), 5);
    wr_en     = 1'b1;
    wr_data   = 8'h3C;
    tx_enable = 1'b1;
    tick();
    wr_en     = 1'b0;
    tx_enable = 1'b0;
    exp_q.push_back(8'h3C);
    check("t6_count_same", 32'(count), 5);
    check("t6_dv", 32'(data_valid), 1);
    wait_state(ST_IDLE, 60, "t6_frame_done");
    for (int i = 0; i < 11; i++) write_byte(8'(8'h90 + i), 1'b1, 1'b0);
    check("t6_full", 32'(full), 1);
    check("t6_ovf_before", 32'(overflow), 0);
    wr_en     = 1'b1;
    wr_data   = 8'hC3;
    tx_enable = 1'b1;
    tick();
    wr_en = 1'b0;
    check("t6_ovf_on_pop", 32'(overflow), 1);
    check("t6_count15", 32'(count), 15);
    check("t6_not_full", 32'(full), 0);
    check("t6_dv2", 32'(data_valid), 1);
    wait_idle(600, "t6_drain");

    // Reset in the middle of a frame with entries queued.
    for (int i = 0; i < 4; i++) write_byte(8'(8'hB0 + i), 1'b1, 1'b0);
    wait_state(ST_WAIT_DONE, 60, "t7_reach_wait_done");
    check("t7_count3", 32'(count), 3);
    reset = 1'b1;
    tick();
    check("t7_count", 32'(count), 0);
    check("t7_empty", 32'(empty), 1);
    check("t7_dv", 32'(data_valid), 0);
    check("t7_tx_idle", 32'(tx_idle), 1);
    check("t7_overflow", 32'(overflow), 0);
    exp_q.delete();
    have_last = 1'b0;
    reset = 1'b0;
    base = dv_cnt;
    repeat (30) tick();
    check("t7_no_launch", dv_cnt - base, 0);
    check("t7_still_idle", 32'(tx_idle), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
